mdu_hilo: RTL and testbench

- Iterative multiply/divide unit that sits beside the ALU in the execute stage.
- Executes MULT/MULTU/DIV/DIVU into HI/LO, which the ALU datapath cannot do in one cycle.
- Services MTHI/MTLO and exposes HI/LO for MFHI/MFLO.
- The controller stalls the PC on busy.

---
 rtl/mdu_hilo_if.sv | 25 ++
 rtl/mdu_hilo.sv | 216 +++++++++++++++++++++
 tb/tb_mdu_hilo.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mdu_hilo_if.sv
// rtl/mdu_hilo_if.sv - operation/result bundle between execute-stage control and the HI/LO unit
//   master : start, MDOp, A, B out; busy, done, HI, LO in (controller side)
//   slave  : start, MDOp, A, B in;  busy, done, HI, LO out (mdu_hilo side)
interface mdu_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       MDOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, MDOp, A, B,
    input  busy, done, HI, LO
  );

  modport slave (
    input  start, MDOp, A, B,
    output busy, done, HI, LO
  );
endinterface

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - iterative multiply/divide unit with HI/LO registers
//   clk   : rising-edge clock
//   rstn  : asynchronous active-low reset
//   bus   : mdu_hilo_if.slave
//           start/MDOp/A/B  operation request, sampled only while idle
//           busy            high while an operation is in flight
//           done            one-cycle pulse when HI/LO hold a new result
//           HI/LO           result registers (also written by MTHI/MTLO)
//   Optional build macro MDU_FAST_MULT_EN: MULT/MULTU finish through a
//   single-cycle combinational multiplier; divide stays iterative.
module mdu_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       rstn,
  mdu_hilo_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_res;   // product / quotient must be negated
  logic             neg_rem;   // remainder takes the dividend's sign
  logic             div_zero;
  logic [WIDTH-1:0] opnd;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi;    // partial product high half / remainder
  logic [WIDTH-1:0] acc_lo;    // multiplier bits / dividend-quotient shifter
  logic [WIDTH-1:0] a_q;       // raw dividend, needed for divide-by-zero HI
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

  // Request decode: sign handling happens once at launch, the loop works on magnitudes.
  logic             req_signed;
  logic             req_is_div;
  logic             req_is_mul;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign req_signed = (bus.MDOp == OP_MULT) || (bus.MDOp == OP_DIV);
  assign req_is_div = (bus.MDOp == OP_DIV)  || (bus.MDOp == OP_DIVU);
  assign req_is_mul = (bus.MDOp == OP_MULT) || (bus.MDOp == OP_MULTU);
  assign a_neg      = req_signed & bus.A[WIDTH-1];
  assign b_neg      = req_signed & bus.B[WIDTH-1];
  assign a_mag      = a_neg ? -bus.A : bus.A;
  assign b_mag      = b_neg ? -bus.B : bus.B;

  // Shift-add step: add multiplicand when the current multiplier bit is set,
  // then shift the 2W-bit accumulator right with the carry coming in on top.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_nxt_hi;
  logic [WIDTH-1:0] mul_nxt_lo;

  assign mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign mul_nxt_hi = mul_sum[WIDTH:1];
  assign mul_nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};

  // Restoring divide step: shift the next dividend bit into the remainder and
  // keep the subtraction only when it does not go negative. Because the
  // remainder stays below the divisor, the trial's top bit is a clean borrow.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_nxt_hi;
  logic [WIDTH-1:0] div_nxt_lo;

  assign div_shift  = {acc_hi, acc_lo[WIDTH-1]};
  assign div_trial  = div_shift - {1'b0, opnd};
  assign div_ge     = ~div_trial[WIDTH];
  assign div_nxt_hi = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_nxt_lo = {acc_lo[WIDTH-2:0], div_ge};

  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;

  assign nxt_hi = is_div ? div_nxt_hi : mul_nxt_hi;
  assign nxt_lo = is_div ? div_nxt_lo : mul_nxt_lo;

  // Final sign fix-up applied to the value produced by the last iteration.
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign prod_mag = {nxt_hi, nxt_lo};
  assign prod_fix = neg_res ? -prod_mag : prod_mag;

  always_comb begin
    res_hi = prod_fix[2*WIDTH-1:WIDTH];
    res_lo = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_hi = neg_rem ? -nxt_hi : nxt_hi;
        res_lo = neg_res ? -nxt_lo : nxt_lo;
      end
    end
  end

`ifdef MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;

  always_comb begin
    if (bus.MDOp == OP_MULT) begin
      fast_prod = $signed({{WIDTH{bus.A[WIDTH-1]}}, bus.A}) *
                  $signed({{WIDTH{bus.B[WIDTH-1]}}, bus.B});
    end else begin
      fast_prod = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            if (req_is_mul || req_is_div) begin
`ifdef MDU_FAST_MULT_EN
              if (req_is_mul) begin
                hi_q   <= fast_prod[2*WIDTH-1:WIDTH];
                lo_q   <= fast_prod[WIDTH-1:0];
                done_q <= 1'b1;
                busy_q <= 1'b1;
                state  <= FIN;
              end else begin
`endif
                is_div   <= req_is_div;
                neg_res  <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                div_zero <= (bus.B == '0);
                a_q      <= bus.A;
                opnd     <= req_is_div ? b_mag : a_mag;
                acc_hi   <= '0;
                acc_lo   <= req_is_div ? a_mag : b_mag;
                cnt      <= CNT_INIT;
                busy_q   <= 1'b1;
                state    <= CALC;
`ifdef MDU_FAST_MULT_EN
              end
`endif
            end else if (bus.MDOp == OP_MTHI) begin
              hi_q <= bus.A;
            end else if (bus.MDOp == OP_MTLO) begin
              lo_q <= bus.A;
            end
          end
        end

        CALC: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt - CNT_ONE;
          if (cnt == '0) begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            done_q <= 1'b1;
            state  <= FIN;
          end
        end

        FIN: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - directed vector bench for mdu_hilo
module tb_mdu_hilo;

  localparam int W = 32;
`ifdef MDU_FAST_MULT_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 32;
`endif
  localparam int DIV_LAT = 32;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  mdu_hilo_if #(.WIDTH(W)) bus ();

  mdu_hilo #(.WIDTH(W), .CNT_W(5)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a request for exactly one rising edge, then scramble A/B.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.MDOp  = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.MDOp  = 3'd0;
    bus.A     = $urandom;
    bus.B     = $urandom;
  endtask

  // Edges after the start edge until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int           n;
    int           pulses;
    logic [W-1:0] hold_hi;
    logic [W-1:0] hold_lo;

    vecs[0] = '{"multu_max",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT};
    vecs[1] = '{"mult_neg",   3'd1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, MUL_LAT};
    vecs[2] = '{"mult_minsq", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_LAT};
    vecs[3] = '{"multu_zero", 3'd2, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, MUL_LAT};
    vecs[4] = '{"div_negdvd", 3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT};
    vecs[5] = '{"div_negdvs", 3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_LAT};
    vecs[6] = '{"divu_zero",  3'd4, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, DIV_LAT};
    vecs[7] = '{"div_ovf",    3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT};
    vecs[8] = '{"divu_basic", 3'd4, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, DIV_LAT};
    vecs[9] = '{"div_zero_s", 3'd3, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, DIV_LAT};

    bus.start = 1'b0;
    bus.MDOp  = 3'd0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_hi", bus.HI, 0);
    chk("reset_lo", bus.LO, 0);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      chk({vecs[i].name, "_busy"}, bus.busy, 1);
      wait_done(n);
      chk({vecs[i].name, "_lat"}, n, vecs[i].lat);
      chk({vecs[i].name, "_hi"}, bus.HI, vecs[i].hi);
      chk({vecs[i].name, "_lo"}, bus.LO, vecs[i].lo);
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_done_fall"}, bus.done, 0);
      chk({vecs[i].name, "_busy_fall"}, bus.busy, 0);
    end

    // MTLO / MTHI while idle: written at the start edge, no busy, no done.
    hold_hi = bus.HI;
    issue(3'd6, 32'h00001234, 32'h0);
    chk("mtlo_lo", bus.LO, 32'h00001234);
    chk("mtlo_hi_kept", bus.HI, hold_hi);
    chk("mtlo_busy", bus.busy, 0);
    chk("mtlo_done", bus.done, 0);
    issue(3'd5, 32'hCAFEF00D, 32'h0);
    chk("mthi_hi", bus.HI, 32'hCAFEF00D);
    chk("mthi_lo_kept", bus.LO, 32'h00001234);

    // Reserved opcode does nothing.
    issue(3'd7, 32'h11111111, 32'h22222222);
    chk("op7_busy", bus.busy, 0);
    chk("op7_hi", bus.HI, 32'hCAFEF00D);
    chk("op7_lo", bus.LO, 32'h00001234);

    // MTHI issued while a DIVU is in flight must be dropped.
    hold_hi = bus.HI;
    issue(3'd4, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.MDOp  = 3'd5;
    bus.A     = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.MDOp  = 3'd0;
    chk("busy_mthi_hi_kept", bus.HI, hold_hi);
    chk("busy_mthi_busy", bus.busy, 1);
    wait_done(n);
    chk("busy_mthi_done_seen", bus.done, 1);
    chk("busy_mthi_rem", bus.HI, 32'd2);
    chk("busy_mthi_quo", bus.LO, 32'd14);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a DIVU: immediate clear, no late done.
    issue(3'd4, 32'd35, 32'd5);
    repeat (10) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_hi", bus.HI, 0);
    chk("abort_lo", bus.LO, 0);
    @(negedge clk);
    rstn = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    chk("abort_idle", bus.busy, 0);

    // Reset mid-CALC of MULTU 5*7 (default build keeps it iterative).
    issue(3'd5, 32'h0000AAAA, 32'h0);
    issue(3'd2, 32'd5, 32'd7);
    hold_lo = bus.LO;
    repeat (4) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("mul_abort_busy", bus.busy, 0);
    chk("mul_abort_hi", bus.HI, 0);
    chk("mul_abort_lo", bus.LO, 0);
    @(negedge clk);
    rstn = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
`ifdef MDU_FAST_MULT_EN
    chk("mul_abort_fast_result", hold_lo, 32'd35);
`else
    chk("mul_abort_no_done", pulses, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
